// File: rtl/axi_burst_pkg.sv
// rtl/axi_burst_pkg.sv - shared states, AXI encodings and 4KB boundary helper for axi_burst
package axi_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_WR    = 2'd2,
      ST_WRESP = 2'd3
   } state_e;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned BOUNDARY_4KB = 4096;

   // True when a burst of 'beats' beats of 'bytes' bytes starting at page offset 'offset'
   // would run past the end of the 4KB page.
   function automatic logic crosses_4kb(input logic [11:0] offset,
                                        input logic [8:0]  beats,
                                        input logic [3:0]  bytes);
      logic [13:0] span;
      span = 14'(beats) * 14'(bytes);
      return (14'(offset) + span) > 14'(BOUNDARY_4KB);
   endfunction

endpackage

// File: rtl/axi_burst.sv
// rtl/axi_burst.sv - native request to single AXI4 INCR burst master, one burst in flight
module axi_burst
   import axi_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BEATS  = 8,
   localparam int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_instr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]      req_len,

   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_W-1:0]     wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,

   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,

   output logic                  done,
   output logic                  err,

   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,

   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_W-1:0]     m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,

   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,

   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,

   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic                    instr_q, instr_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic                    a_done_q, a_done_d;   // AR or AW accepted for the current burst
   logic                    w_done_q, w_done_d;   // last W beat accepted
   logic                    sticky_q, sticky_d;   // any read beat returned an error
   logic                    fault_q, fault_d;     // 4KB-crossing request rejected last cycle

   logic                    wlast;
   logic                    aw_fire;
   logic                    w_fire;

   // Address channel attributes are fixed except for address, length and instruction bit;
   // both channels carry the same values and only the valid decides which one is live.
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'(len_q);
   assign m_axi_awsize  = AXSIZE;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = {instr_q, 2'b00};
   assign m_axi_awqos   = 4'd0;

   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'(len_q);
   assign m_axi_arsize  = AXSIZE;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd0;
   assign m_axi_arprot  = {instr_q, 2'b00};
   assign m_axi_arqos   = 4'd0;

   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign rd_data       = m_axi_rdata;

   assign wlast         = (cnt_q == len_q);
   assign m_axi_wlast   = wlast;

   // State and burst bookkeeping registers; reset abandons any burst in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         instr_q  <= 1'b0;
         cnt_q    <= '0;
         a_done_q <= 1'b0;
         w_done_q <= 1'b0;
         sticky_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         instr_q  <= instr_d;
         cnt_q    <= cnt_d;
         a_done_q <= a_done_d;
         w_done_q <= w_done_d;
         sticky_q <= sticky_d;
         fault_q  <= fault_d;
      end
   end

   // Next-state and handshake outputs; every output is gated by state so reset (which forces
   // IDLE) clears them at once, with req_ready additionally held low while rst is asserted.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      instr_d       = instr_q;
      cnt_d         = cnt_q;
      a_done_d      = a_done_q;
      w_done_d      = w_done_q;
      sticky_d      = sticky_q;
      fault_d       = 1'b0;

      req_ready     = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      done          = fault_q;
      err           = fault_q;
      aw_fire       = 1'b0;
      w_fire        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = rst;
            if (req_valid) begin
               addr_d   = req_addr;
               len_d    = req_len;
               instr_d  = req_instr;
               cnt_d    = '0;
               a_done_d = 1'b0;
               w_done_d = 1'b0;
               sticky_d = 1'b0;
               if (crosses_4kb(req_addr[11:0], 9'(req_len) + 9'd1, 4'(STRB_W))) begin
                  fault_d = 1'b1;
               end else begin
                  state_d = req_write ? ST_WR : ST_RD;
               end
            end
         end

         ST_RD: begin
            m_axi_arvalid = !a_done_q;
            m_axi_rready  = 1'b1;
            if (m_axi_arvalid && m_axi_arready) begin
               a_done_d = 1'b1;
            end
            rd_valid = m_axi_rvalid;
            rd_last  = m_axi_rvalid && m_axi_rlast;
            if (m_axi_rvalid) begin
               if (m_axi_rresp != RESP_OKAY) begin
                  sticky_d = 1'b1;
               end
               if (m_axi_rlast) begin
                  done    = 1'b1;
                  err     = sticky_q || (m_axi_rresp != RESP_OKAY);
                  state_d = ST_IDLE;
               end
            end
         end

         ST_WR: begin
            m_axi_awvalid = !a_done_q;
            m_axi_wvalid  = wr_valid && !w_done_q;
            wr_ready      = m_axi_wready && !w_done_q;
            aw_fire       = m_axi_awvalid && m_axi_awready;
            w_fire        = m_axi_wvalid && m_axi_wready;
            if (aw_fire) begin
               a_done_d = 1'b1;
            end
            if (w_fire) begin
               if (wlast) begin
                  w_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            if ((a_done_q || aw_fire) && (w_done_q || (w_fire && wlast))) begin
               state_d = ST_WRESP;
            end
         end

         ST_WRESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               done    = 1'b1;
               err     = (m_axi_bresp != RESP_OKAY);
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_burst.sv
// tb/tb_axi_burst.sv - directed self-checking bench for axi_burst
module tb_axi_burst;
   import axi_burst_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_instr;
   logic [31:0] req_addr;
   logic [2:0]  req_len;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, done, err;
   logic [31:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst;
   logic        m_axi_awlock, m_axi_arlock;
   logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
   logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   axi_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BEATS(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_instr(req_instr), .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .done(done), .err(err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_read(input logic [31:0] addr, input logic [2:0] len, input int ar_delay,
                           input int err_beat, input logic instr, input logic exp_err);
      int  beat = 0;
      int  arv_cycles = 0;
      int  ndone = 0;
      int  nlast = 0;
      bit  ar_ok = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len; req_instr = instr;
      @(negedge clk);
      check_val("rd_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int g = 0; g < 200 && ndone == 0; g++) begin
         m_axi_arready = (g >= ar_delay);
         m_axi_rvalid  = ar_ok;
         m_axi_rdata   = 32'hA000_0000 + 32'(beat);
         m_axi_rresp   = (beat == err_beat) ? RESP_SLVERR : RESP_OKAY;
         m_axi_rlast   = ar_ok && (beat == int'(len));
         @(negedge clk);
         if (g == 0) begin
            check_val("rd_arvalid_first", m_axi_arvalid, 1'b1);
            check_val("rd_araddr", m_axi_araddr, addr);
            check_val("rd_arlen", m_axi_arlen, {5'd0, len});
            check_val("rd_arsize", m_axi_arsize, 3'd2);
            check_val("rd_arburst", m_axi_arburst, 2'b01);
            check_val("rd_arprot", m_axi_arprot, {instr, 2'b00});
            check_val("rd_rready", m_axi_rready, 1'b1);
         end
         if (m_axi_arvalid) arv_cycles++;
         if (m_axi_rvalid) begin
            check_val("rd_valid", rd_valid, 1'b1);
            check_val("rd_data", rd_data, 32'hA000_0000 + 32'(beat));
            check_val("rd_last", rd_last, beat == int'(len));
            if (rd_last) nlast++;
         end
         if (done) begin
            ndone++;
            check_val("rd_done_at_last", beat, len);
            check_val("rd_err", err, exp_err);
         end
         if (m_axi_arvalid && m_axi_arready) ar_ok = 1;
         if (m_axi_rvalid) beat++;
         @(posedge clk); #1;
      end
      m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rlast = 1'b0;
      check_val("rd_done_count", ndone, 1);
      check_val("rd_beats", beat, int'(len) + 1);
      check_val("rd_last_count", nlast, 1);
      check_val("rd_arvalid_cycles", arv_cycles, ar_delay + 1);
      @(negedge clk);
      check_val("rd_idle_done", done, 1'b0);
      check_val("rd_idle_req_ready", req_ready, 1'b1);
   endtask

   task automatic run_write(input logic [31:0] addr, input logic [2:0] len, input bit wready_toggle,
                            input bit aw_after_w, input logic [1:0] bresp, input logic exp_err);
      int  wbeat = 0;
      int  nlast = 0;
      int  ndone = 0;
      bit  aw_ok = 0;
      bit  resp_phase = 0;
      bit  b_checked = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len; req_instr = 1'b0;
      @(negedge clk);
      check_val("wr_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int g = 0; g < 200 && ndone == 0; g++) begin
         wr_valid      = (wbeat <= int'(len));
         wr_data       = 32'hB000_0000 + 32'(wbeat);
         wr_strb       = 4'(wbeat + 1);
         m_axi_wready  = wready_toggle ? g[0] : 1'b1;
         m_axi_awready = aw_after_w ? (wbeat > int'(len)) : 1'b1;
         resp_phase    = aw_ok && (wbeat > int'(len));
         m_axi_bvalid  = resp_phase;
         m_axi_bresp   = bresp;
         @(negedge clk);
         if (resp_phase && !b_checked) begin
            check_val("wr_bready", m_axi_bready, 1'b1);
            b_checked = 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            check_val("wr_wdata", m_axi_wdata, 32'hB000_0000 + 32'(wbeat));
            check_val("wr_wstrb", m_axi_wstrb, 4'(wbeat + 1));
            check_val("wr_wlast", m_axi_wlast, wbeat == int'(len));
            check_val("wr_ready", wr_ready, 1'b1);
            if (m_axi_wlast) nlast++;
            wbeat++;
         end
         if (m_axi_awvalid && m_axi_awready) begin
            check_val("wr_awaddr", m_axi_awaddr, addr);
            check_val("wr_awlen", m_axi_awlen, {5'd0, len});
            aw_ok = 1;
         end
         if (done) begin
            ndone++;
            check_val("wr_done_in_resp", resp_phase, 1'b1);
            check_val("wr_err", err, exp_err);
         end
         @(posedge clk); #1;
      end
      m_axi_bvalid = 1'b0; wr_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      check_val("wr_done_count", ndone, 1);
      check_val("wr_beats", wbeat, int'(len) + 1);
      check_val("wr_wlast_count", nlast, 1);
      @(negedge clk);
      check_val("wr_idle_done", done, 1'b0);
      check_val("wr_idle_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b0;
      req_valid = 0; req_write = 0; req_instr = 0; req_addr = '0; req_len = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;

      repeat (3) @(negedge clk);
      check_val("rst_req_ready", req_ready, 1'b0);
      check_val("rst_arvalid", m_axi_arvalid, 1'b0);
      check_val("rst_awvalid", m_axi_awvalid, 1'b0);
      check_val("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_val("post_rst_req_ready", req_ready, 1'b1);

      run_read(32'h100, 3'd7, 3, -1, 1'b0, 1'b0);
      run_write(32'h200, 3'd3, 1'b1, 1'b1, RESP_OKAY, 1'b0);
      run_read(32'h400, 3'd3, 0, 1, 1'b1, 1'b1);
      run_read(32'hFE0, 3'd7, 0, -1, 1'b0, 1'b0);

      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFF8; req_len = 3'd7;
      @(negedge clk);
      check_val("kb4_req_ready", req_ready, 1'b1);
      check_val("kb4_done_early", done, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_val("kb4_done", done, 1'b1);
      check_val("kb4_err", err, 1'b1);
      check_val("kb4_req_ready_after", req_ready, 1'b1);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_axi_arvalid || m_axi_awvalid) cnt++;
         @(negedge clk);
      end
      check_val("kb4_no_axi", cnt, 0);
      check_val("kb4_done_cleared", done, 1'b0);

      run_write(32'h500, 3'd0, 1'b0, 1'b0, RESP_DECERR, 1'b1);

      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_len = 3'd3;
      @(posedge clk); #1;
      req_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hC0; wr_strb = 4'hF;
      m_axi_wready = 1'b1; m_axi_awready = 1'b0;
      @(posedge clk); #1;
      wr_data = 32'hC1;
      @(negedge clk);
      check_val("mid_wvalid_before", m_axi_wvalid, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check_val("mid_rst_awvalid", m_axi_awvalid, 1'b0);
      check_val("mid_rst_wvalid", m_axi_wvalid, 1'b0);
      check_val("mid_rst_bready", m_axi_bready, 1'b0);
      check_val("mid_rst_wr_ready", wr_ready, 1'b0);
      check_val("mid_rst_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1; wr_valid = 1'b0; m_axi_wready = 1'b0;
      @(negedge clk);
      check_val("mid_rel_req_ready", req_ready, 1'b1);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (done || m_axi_awvalid || m_axi_wvalid) cnt++;
         @(negedge clk);
      end
      check_val("mid_no_done", cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
